// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler
//   Receive-side bit sampler for the UART. Synchronises the raw RX line,
//   detects a start bit on acquisition ticks and takes three votes around the
//   middle of every bit. It assembles LSB-first data, with an optional parity
//   bit, and presents the byte plus its status when the stop bit is sampled.
//
//   Ports
//     clk          system clock
//     rst          asynchronous reset, active-low
//     AcqSig_i     1-clk acquisition strobe; all sampling happens on these ticks
//     AcqPerBit_i  ticks per bit (values below 3 act as 3), latched at start
//     ParityEn_i   a parity bit follows the data bits (latched at start)
//     ParityOdd_i  1 = odd parity, 0 = even parity (latched at start)
//     Rx_i         raw serial line, idles high
//     Data_o       last received data word
//     DataValid_o  1-clk pulse when a frame completes
//     FrameErr_o   stop bit voted 0 (held until the next DataValid_o)
//     ParityErr_o  parity mismatch (held until the next DataValid_o)
//     Busy_o       state is not IDLE
//
//   Optional build macro UART_RX_OVERRUN_EN adds DataAck_i / Overrun_o.
//   When it is set, a pending flag is raised on every DataValid_o and cleared
//   by DataAck_i. A new frame that arrives while the flag is still set reports
//   Overrun_o with its pulse.
//
//   state  | meaning
//   IDLE   | waiting for a low sample on a tick
//   START  | voting the start bit; a high vote is a false start
//   DATA   | shifting DATA_BITS voted bits in, LSB first
//   PARITY | voting the parity bit
//   STOP   | voting the stop bit; the frame completes at tick mid+1
module uart_rx_bit_sampler #(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 AcqSig_i,
   input  logic [4:0]           AcqPerBit_i,
   input  logic                 ParityEn_i,
   input  logic                 ParityOdd_i,
   input  logic                 Rx_i,
`ifdef UART_RX_OVERRUN_EN
   input  logic                 DataAck_i,
   output logic                 Overrun_o,
`endif
   output logic [DATA_BITS-1:0] Data_o,
   output logic                 DataValid_o,
   output logic                 FrameErr_o,
   output logic                 ParityErr_o,
   output logic                 Busy_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic [4:0]             n_q, tick_q, mid, n_clamp;
   logic                   s0_q, s1_q, s2_q, s2_eff, vote;
   logic [3:0]             bit_idx_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   par_en_q, par_odd_q, pbit_q;
   logic                   at_boundary, at_late, start_det, frame_done;

   assign rx_s    = sync_q[SYNC_STAGES-1];
   assign n_clamp = (AcqPerBit_i < 5'd3) ? 5'd3 : AcqPerBit_i;
   assign mid     = n_q >> 1;

   assign at_boundary = AcqSig_i && (tick_q == n_q - 5'd1);
   assign at_late     = AcqSig_i && (tick_q == mid + 5'd1);
   assign start_det   = (state_q == ST_IDLE) && AcqSig_i && !rx_s;
   assign frame_done  = (state_q == ST_STOP) && at_late;

   // For short bits (N = 3 or 4) the third sample lands on the boundary tick
   // itself, so the vote must see the live sample instead of the register.
   assign s2_eff = (tick_q == mid + 5'd1) ? rx_s : s2_q;
   assign vote   = (s0_q & s1_q) | (s0_q & s2_eff) | (s1_q & s2_eff);

   assign Busy_o = (state_q != ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_det) state_d = ST_START;
         ST_START:  if (at_boundary) state_d = vote ? ST_IDLE : ST_DATA;
         ST_DATA:   if (at_boundary && bit_idx_q == LAST_BIT)
                       state_d = par_en_q ? ST_PARITY : ST_STOP;
         ST_PARITY: if (at_boundary) state_d = ST_STOP;
         ST_STOP:   if (at_late) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q      <= '1;
         n_q         <= 5'd3;
         tick_q      <= '0;
         s0_q        <= 1'b1;
         s1_q        <= 1'b1;
         s2_q        <= 1'b1;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         par_en_q    <= 1'b0;
         par_odd_q   <= 1'b0;
         pbit_q      <= 1'b0;
         Data_o      <= '0;
         DataValid_o <= 1'b0;
         FrameErr_o  <= 1'b0;
         ParityErr_o <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], Rx_i};
         DataValid_o <= frame_done;
         if (start_det) begin
            n_q       <= n_clamp;
            tick_q    <= 5'd1;
            // The detecting tick is index 0 and is known to be low.
            s0_q      <= 1'b0;
            bit_idx_q <= '0;
            par_en_q  <= ParityEn_i;
            par_odd_q <= ParityOdd_i;
         end else if (state_q != ST_IDLE && AcqSig_i) begin
            tick_q <= at_boundary ? 5'd0 : tick_q + 5'd1;
            if (tick_q == mid - 5'd1) s0_q <= rx_s;
            if (tick_q == mid)        s1_q <= rx_s;
            if (tick_q == mid + 5'd1) s2_q <= rx_s;
            if (at_boundary && state_q == ST_DATA) begin
               shift_q   <= {vote, shift_q[DATA_BITS-1:1]};
               bit_idx_q <= bit_idx_q + 4'd1;
            end
            if (at_boundary && state_q == ST_PARITY) pbit_q <= vote;
            if (frame_done) begin
               tick_q      <= '0;
               Data_o      <= shift_q;
               FrameErr_o  <= ~vote;
               ParityErr_o <= par_en_q & ((^shift_q ^ pbit_q) != par_odd_q);
            end
         end
      end
   end

`ifdef UART_RX_OVERRUN_EN
   logic pending_q;

   // A frame completing in the same clk as DataAck_i keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= 1'b0;
         Overrun_o <= 1'b0;
      end else if (frame_done) begin
         Overrun_o <= pending_q;
         pending_q <= 1'b1;
      end else if (DataAck_i) begin
         pending_q <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
module tb_uart_rx_bit_sampler;

   typedef struct {
      logic [7:0] data;
      logic       fe;
      logic       pe;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       acq = 1'b0;
   logic [4:0] AcqPerBit_i = 5'd16;
   logic       ParityEn_i = 1'b0;
   logic       ParityOdd_i = 1'b0;
   logic       Rx_i = 1'b1;
   logic [7:0] Data_o;
   logic       DataValid_o, FrameErr_o, ParityErr_o, Busy_o;
`ifdef UART_RX_OVERRUN_EN
   logic       DataAck_i = 1'b0;
   logic       Overrun_o;
`endif

   int   checks = 0;
   int   errors = 0;
   bit   do_ack = 1'b1;
   exp_t sb[$];
   int   cnt = 0;

   uart_rx_bit_sampler #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
      .clk(clk),
      .rst(rst),
      .AcqSig_i(acq),
      .AcqPerBit_i(AcqPerBit_i),
      .ParityEn_i(ParityEn_i),
      .ParityOdd_i(ParityOdd_i),
      .Rx_i(Rx_i),
`ifdef UART_RX_OVERRUN_EN
      .DataAck_i(DataAck_i),
      .Overrun_o(Overrun_o),
`endif
      .Data_o(Data_o),
      .DataValid_o(DataValid_o),
      .FrameErr_o(FrameErr_o),
      .ParityErr_o(ParityErr_o),
      .Busy_o(Busy_o)
   );

   always #5 clk = ~clk;

   // One acquisition tick every 4 clks.
   initial begin
      forever begin
         @(negedge clk);
         acq = (cnt == 3);
         cnt = (cnt + 1) % 4;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_tick();
      do @(posedge clk); while (acq != 1'b1);
   endtask

   task automatic send_bit(input bit v, input int n);
      #1 Rx_i = v;
      repeat (n) wait_tick();
   endtask

   task automatic pulse_ack();
`ifdef UART_RX_OVERRUN_EN
      @(negedge clk) DataAck_i = 1'b1;
      @(negedge clk) DataAck_i = 1'b0;
`endif
   endtask

   task automatic send_frame(input logic [7:0] d, input int n, input bit par, input bit pbit,
                             input bit stop, input int glitch, input bit chg, input exp_t e);
      int mid;
      mid = n / 2;
      sb.push_back(e);
      wait_tick();
      send_bit(1'b0, n);
      if (chg) AcqPerBit_i = 5'd4;
      for (int i = 0; i < 8; i++) begin
         if (i == glitch) begin
            send_bit(d[i], mid);
            send_bit(~d[i], 1);
            send_bit(d[i], n - mid - 1);
         end else begin
            send_bit(d[i], n);
         end
      end
      if (par) send_bit(pbit, n);
      #1 Rx_i = stop;
      repeat (mid + 2) wait_tick();
      #1 chk("latency_valid", int'(DataValid_o), 1);
      repeat (n - mid - 2) wait_tick();
      send_bit(1'b1, 20);
      if (do_ack) pulse_ack();
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (DataValid_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("data", int'(Data_o), int'(e.data));
               chk("frame_err", int'(FrameErr_o), int'(e.fe));
               chk("parity_err", int'(ParityErr_o), int'(e.pe));
               chk("busy_at_valid", int'(Busy_o), 0);
`ifdef UART_RX_OVERRUN_EN
               chk("overrun", int'(Overrun_o), int'(e.ov));
`endif
               @(negedge clk);
               chk("valid_one_clk", int'(DataValid_o), 0);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      repeat (3) @(negedge clk);
      chk("rst_data", int'(Data_o), 0);
      chk("rst_valid", int'(DataValid_o), 0);
      chk("rst_fe", int'(FrameErr_o), 0);
      chk("rst_pe", int'(ParityErr_o), 0);
      chk("rst_busy", int'(Busy_o), 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // 1: N=16, no parity, 0x55
      AcqPerBit_i = 5'd16; ParityEn_i = 1'b0;
      e = '{8'h55, 1'b0, 1'b0, 1'b0};
      send_frame(8'h55, 16, 0, 0, 1, -1, 0, e);
      chk("busy_after_frame", int'(Busy_o), 0);

      // 2: N=15, even parity, 0xA3 with good and bad parity bit
      AcqPerBit_i = 5'd15; ParityEn_i = 1'b1; ParityOdd_i = 1'b0;
      e = '{8'hA3, 1'b0, 1'b0, 1'b0};
      send_frame(8'hA3, 15, 1, 0, 1, -1, 0, e);
      e = '{8'hA3, 1'b0, 1'b1, 1'b0};
      send_frame(8'hA3, 15, 1, 1, 1, -1, 0, e);
      // odd parity, 0x07 has three ones, parity bit 0 is correct
      ParityOdd_i = 1'b1;
      e = '{8'h07, 1'b0, 1'b0, 1'b0};
      send_frame(8'h07, 15, 1, 0, 1, -1, 0, e);
      ParityEn_i = 1'b0; ParityOdd_i = 1'b0;

      // 3: false start of 4 ticks at N=16
      AcqPerBit_i = 5'd16;
      wait_tick();
      send_bit(1'b0, 4);
      #1 chk("false_start_busy", int'(Busy_o), 1);
      send_bit(1'b1, 13);
      #1 chk("false_start_idle", int'(Busy_o), 0);

      // 4: break frame then a clean frame clears FrameErr
      e = '{8'h00, 1'b1, 1'b0, 1'b0};
      send_frame(8'h00, 16, 0, 0, 0, -1, 0, e);
      e = '{8'h3C, 1'b0, 1'b0, 1'b0};
      send_frame(8'h3C, 16, 0, 0, 1, -1, 0, e);

      // 5: 1-tick glitch at mid of data bit 3
      e = '{8'hFF, 1'b0, 1'b0, 1'b0};
      send_frame(8'hFF, 16, 0, 0, 1, 3, 0, e);

      // clamp: AcqPerBit=2 acts as 3 ticks per bit
      AcqPerBit_i = 5'd2;
      e = '{8'h5A, 1'b0, 1'b0, 1'b0};
      send_frame(8'h5A, 3, 0, 0, 1, -1, 0, e);

      // mid-frame config change has no effect
      AcqPerBit_i = 5'd16;
      e = '{8'hC3, 1'b0, 1'b0, 1'b0};
      send_frame(8'hC3, 16, 0, 0, 1, -1, 1, e);
      AcqPerBit_i = 5'd16;

      // 5b: reset during data bit 4
      wait_tick();
      send_bit(1'b0, 16);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
      send_bit(1'b1, 5);
      chk("busy_mid_frame", int'(Busy_o), 1);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", int'(Busy_o), 0);
      chk("reset_data", int'(Data_o), 0);
      rst = 1'b1;
      repeat (400) @(negedge clk);

`ifdef UART_RX_OVERRUN_EN
      // 6: overrun
      do_ack = 1'b0;
      e = '{8'h11, 1'b0, 1'b0, 1'b0};
      send_frame(8'h11, 16, 0, 0, 1, -1, 0, e);
      e = '{8'h22, 1'b0, 1'b0, 1'b1};
      send_frame(8'h22, 16, 0, 0, 1, -1, 0, e);
      pulse_ack();
      do_ack = 1'b1;
      e = '{8'h33, 1'b0, 1'b0, 1'b0};
      send_frame(8'h33, 16, 0, 0, 1, -1, 0, e);
`endif

      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_bit_sampler.md
Name: uart_rx_bit_sampler

Overview:
- Receive-side bit sampler that consumes the 1-clk acquisition strobe from the baudrate generator.
- Oversamples the serial RX line at AcqSig_i ticks, detects the start bit and majority-votes three mid-bit samples per bit.
- Assembles LSB-first data with optional parity, checks the stop bit and presents a received byte with status to the RX buffer above.

Parameters:
DATA_BITS, 8, data bits per frame (5..8 supported)
SYNC_STAGES, 2, flip-flop stages on Rx_i before sampling (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
AcqSig_i  in  1  acquisition strobe, 1 clk wide; this block samples only on these ticks
AcqPerBit_i  in  5  ticks per bit = up count + down count from the compensation config; values below 3 are treated as 3
ParityEn_i  in  1  1 = a parity bit follows the data bits
ParityOdd_i  in  1  1 = odd parity, 0 = even parity
Rx_i  in  1  raw serial line, idles high
Data_o  out  DATA_BITS  last received data word
DataValid_o  out  1  1-clk pulse when a frame completes
FrameErr_o  out  1  stop bit voted 0; valid together with DataValid_o
ParityErr_o  out  1  parity mismatch; valid together with DataValid_o
Busy_o  out  1  high whenever the state is not IDLE

Behaviour:
Reset values:
- All outputs 0. Data_o = 0.
- Synchronizer stages reset to 1 (line idle).
- State IDLE.

Synchronizer and configuration latch:
- Rx_i passes through SYNC_STAGES FFs; rx_s is the last stage.
- N is AcqPerBit_i (after clamping to >= 3), latched at start detection.
- N is held constant for the whole frame; changing AcqPerBit_i mid-frame has no effect.
- mid = N >> 1. Vote samples are taken at tick indices mid-1, mid, mid+1 within each bit. Result = majority of the three.

Tick counter:
- tick_cnt counts 0..N-1 and advances only on AcqSig_i.
- It wraps to 0 on the tick after N-1; that wrap marks the bit boundary.

States:
- IDLE: on an AcqSig_i tick with rx_s=0, latch N, set tick_cnt=1 (the detecting tick is index 0), go to START.
- START: after vote completes at the bit boundary: vote=1 is a false start, return to IDLE with no outputs. vote=0 goes to DATA with bit_idx=0.
- DATA: at each bit boundary, shift the vote into the data register LSB-first and increment bit_idx. After DATA_BITS bits, go to PARITY if ParityEn_i (sampled at start) is set, otherwise go to STOP.
- PARITY: vote gives pbit. Error when XOR(data) ^ pbit != ParityOdd. Then go to STOP.
- STOP: once the mid+1 sample is taken (half bit early, to allow resync to the next start), on the next clk:
  - DataValid_o=1 for exactly 1 clk;
  - Data_o is updated;
  - FrameErr_o = ~vote;
  - ParityErr_o as computed (0 if parity disabled);
  - go to IDLE.
- FrameErr_o and ParityErr_o hold their value until the next DataValid_o.

Boundary conditions:
- No state or counter change without AcqSig_i, except the DataValid_o pulse and its return to IDLE.
- A break condition (line held 0) yields a frame with Data_o=0 and FrameErr_o=1. IDLE then re-detects a start on the next tick while the line stays low.
- A glitch of 1 sample inside a bit is rejected by the vote.
- Reset asserted mid-frame returns to IDLE immediately. No DataValid_o is produced.

Latency:
- DataValid_o fires 1 clk after the AcqSig_i tick at stop-bit index mid+1.

Optional Feature:
UART_RX_OVERRUN_EN
- Defined: adds input DataAck_i (1 clk pulse, clears the pending flag) and output Overrun_o.
  - A pending flag is set on DataValid_o.
  - If a new DataValid_o occurs while the flag is still set, Overrun_o=1 with that pulse. Data_o is still overwritten, and the flag stays set.
  - Overrun_o holds until the next DataValid_o.
  - DataAck_i in the same clk as DataValid_o: set wins.
- Undefined: neither port exists and no pending logic is generated.

Test Plan:
1. N=16, no parity, Rx frame 0x55 (start, 1010_1010 LSB-first, stop 1) -> DataValid_o one pulse, Data_o=0x55, FrameErr_o=0, ParityErr_o=0, Busy_o low afterwards.
2. N=15, even parity, byte 0xA3 with correct parity bit 0 -> Data_o=0xA3, ParityErr_o=0; repeat with parity bit 1 -> ParityErr_o=1.
3. Rx low for 4 ticks only (N=16) -> false start: back to IDLE, no DataValid_o, Busy_o pulses then returns to 0.
4. Stop bit driven 0, byte 0x00 -> Data_o=0x00, FrameErr_o=1; line released -> the next valid frame 0x3C clears FrameErr_o.
5. A 1-tick 0-glitch at index mid inside data bit 3 of 0xFF -> Data_o=0xFF. Reset asserted at data bit 4 -> Busy_o=0 next clk, no DataValid_o.
6. With UART_RX_OVERRUN_EN: two frames 0x11, 0x22 with no DataAck_i -> second pulse has Overrun_o=1, Data_o=0x22; DataAck_i then frame 0x33 -> Overrun_o=0.
